// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between the instruction-fetch port and the
// load/store port: data wins, with a starvation guard that eventually forces a fetch grant.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_valid,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ready,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_if_flush,
  input  logic              i_d_valid,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic              i_d_we,
  input  logic [1:0]        i_d_width,
  input  logic              i_d_zeroextend,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ready,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [1:0]        o_mem_width,
  output logic              o_mem_zeroextend,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [3:0] STARVE_SAT = 4'hF;

  state_e            state_q, state_d;
  owner_e            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        width_q;
  logic              zext_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        starve_q;
  logic              flush_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              grant_d;
  logic              grant_if;

  // Grant decision only exists in IDLE; data loses once the fetch has waited long enough.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    grant_d  = 1'b0;
    grant_if = 1'b0;
    if (state_q == IDLE) begin
      grant_d  = i_d_valid && (!i_if_valid || (starve_q < STARVE_MAX));
      grant_if = !grant_d && i_if_valid;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_d || grant_if) state_d = ISSUE;
      ISSUE:   if (i_mem_ready)         state_d = WAIT;
      WAIT:    if (i_mem_rvalid)        state_d = RESP;
      RESP:                             state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    o_d_ready   = grant_d;
    o_if_ready  = grant_if;
    o_mem_valid = (state_q == ISSUE);
    o_d_rvalid  = (state_q == RESP) && (owner_q == OWN_D);
    o_if_rvalid = (state_q == RESP) && (owner_q == OWN_IF) && !flush_q;
  end

  assign o_mem_addr       = addr_q;
  assign o_mem_we         = we_q;
  assign o_mem_width      = width_q;
  assign o_mem_zeroextend = zext_q;
  assign o_mem_wdata      = wdata_q;
  assign o_if_rdata       = if_rdata_q;
  assign o_d_rdata        = d_rdata_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      width_q    <= 2'd0;
      zext_q     <= 1'b0;
      wdata_q    <= '0;
      starve_q   <= 4'd0;
      flush_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant_d) begin
        owner_q  <= OWN_D;
        addr_q   <= i_d_addr;
        we_q     <= i_d_we;
        width_q  <= i_d_width;
        zext_q   <= i_d_zeroextend;
        wdata_q  <= i_d_wdata;
        // Only data grants that overtake a waiting fetch count toward starvation.
        if (!i_if_valid)                starve_q <= 4'd0;
        else if (starve_q != STARVE_SAT) starve_q <= starve_q + 4'd1;
      end else if (grant_if) begin
        owner_q  <= OWN_IF;
        addr_q   <= i_if_addr;
        we_q     <= 1'b0;
        width_q  <= 2'd2;
        zext_q   <= 1'b0;
        wdata_q  <= '0;
        starve_q <= 4'd0;
      end

      if ((state_q == WAIT) && i_mem_rvalid) begin
        if (owner_q == OWN_D) d_rdata_q  <= we_q ? '0 : i_mem_rdata;
        else                  if_rdata_q <= i_mem_rdata;
      end

      // A flushed fetch still drains downstream; only its response pulse is dropped.
      if (state_q == IDLE)                          flush_q <= 1'b0;
      else if (i_if_flush && (owner_q == OWN_IF))   flush_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, a transaction-level reference model
// compared every cycle, and literal expectations for the key scenarios.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_if_valid;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_ready;
  logic              o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;
  logic              i_if_flush;
  logic              i_d_valid;
  logic [ADDR_W-1:0] i_d_addr;
  logic              i_d_we;
  logic [1:0]        i_d_width;
  logic              i_d_zeroextend;
  logic [DATA_W-1:0] i_d_wdata;
  logic              o_d_ready;
  logic              o_d_rvalid;
  logic [DATA_W-1:0] o_d_rdata;
  logic              o_mem_valid;
  logic              i_mem_ready;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_we;
  logic [1:0]        o_mem_width;
  logic              o_mem_zeroextend;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              i_mem_rvalid;
  logic [DATA_W-1:0] i_mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_if_valid(i_if_valid), .i_if_addr(i_if_addr), .o_if_ready(o_if_ready),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata), .i_if_flush(i_if_flush),
    .i_d_valid(i_d_valid), .i_d_addr(i_d_addr), .i_d_we(i_d_we), .i_d_width(i_d_width),
    .i_d_zeroextend(i_d_zeroextend), .i_d_wdata(i_d_wdata), .o_d_ready(o_d_ready),
    .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
    .o_mem_we(o_mem_we), .o_mem_width(o_mem_width), .o_mem_zeroextend(o_mem_zeroextend),
    .o_mem_wdata(o_mem_wdata), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: ready after mem_wait ISSUE cycles, response rsp_delay cycles later.
  int                mem_wait  = 0;
  int                rsp_delay = 0;
  logic [DATA_W-1:0] mem_data  = '0;
  int                issue_cnt = 0;
  int                rsp_cnt   = -1;
  bit                hs;

  initial begin : responder
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    forever begin
      @(negedge i_clk);
      hs = i_rst_n && o_mem_valid && i_mem_ready;
      if (!i_rst_n)                 issue_cnt = 0;
      else if (o_mem_valid && !hs)  issue_cnt++;
      @(posedge i_clk);
      #1;
      i_mem_rvalid = 1'b0;
      if (hs) begin
        issue_cnt = 0;
        rsp_cnt   = rsp_delay;
      end
      if (rsp_cnt == 0) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = mem_data;
        rsp_cnt      = -1;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
      end
      i_mem_ready = (issue_cnt >= mem_wait);
    end
  end

  // Reference model: one outstanding transaction tracked through its lifecycle.
  bit                m_busy, m_issued, m_resp, m_own_d, m_flushed;
  logic [ADDR_W-1:0] m_addr;
  logic              m_we, m_zext;
  logic [1:0]        m_width;
  logic [DATA_W-1:0] m_wdata, m_data;
  int                m_streak;
  bit                grant_log[$];

  initial begin : scoreboard
    bit d_pick, if_pick;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        check("rst_ctrl", 64'({o_if_ready, o_if_rvalid, o_d_ready, o_d_rvalid, o_mem_valid,
                               o_mem_we, o_mem_width, o_mem_zeroextend}), 64'h0);
        check("rst_mem_addr",  64'(o_mem_addr),  64'h0);
        check("rst_mem_wdata", 64'(o_mem_wdata), 64'h0);
        check("rst_if_rdata",  64'(o_if_rdata),  64'h0);
        check("rst_d_rdata",   64'(o_d_rdata),   64'h0);
        m_busy = 0; m_issued = 0; m_resp = 0; m_flushed = 0; m_streak = 0;
        continue;
      end
      d_pick  = !m_busy && i_d_valid && (!i_if_valid || (m_streak < STARVE_LIMIT));
      if_pick = !m_busy && !d_pick && i_if_valid;
      check("d_ready",   64'(o_d_ready),   64'(d_pick));
      check("if_ready",  64'(o_if_ready),  64'(if_pick));
      check("mem_valid", 64'(o_mem_valid), 64'(m_busy && !m_issued));
      check("d_rvalid",  64'(o_d_rvalid),  64'(m_resp && m_own_d));
      check("if_rvalid", 64'(o_if_rvalid), 64'(m_resp && !m_own_d && !m_flushed));
      if (m_busy && !m_issued) begin
        check("mem_addr",  64'(o_mem_addr),       64'(m_addr));
        check("mem_we",    64'(o_mem_we),         64'(m_we));
        check("mem_width", 64'(o_mem_width),      64'(m_width));
        check("mem_zext",  64'(o_mem_zeroextend), 64'(m_zext));
        if (m_we) check("mem_wdata", 64'(o_mem_wdata), 64'(m_wdata));
      end
      if (m_resp && m_own_d)                check("d_rdata",  64'(o_d_rdata),  64'(m_data));
      if (m_resp && !m_own_d && !m_flushed) check("if_rdata", 64'(o_if_rdata), 64'(m_data));
      if (o_d_ready)  grant_log.push_back(1'b1);
      if (o_if_ready) grant_log.push_back(1'b0);

      // Advance the model to what the next rising edge produces.
      if (m_busy && !m_own_d && i_if_flush) m_flushed = 1;
      if (!m_busy) begin
        if (d_pick) begin
          m_busy = 1; m_own_d = 1; m_addr = i_d_addr; m_we = i_d_we;
          m_width = i_d_width; m_zext = i_d_zeroextend; m_wdata = i_d_wdata;
          m_streak = i_if_valid ? ((m_streak >= 15) ? 15 : m_streak + 1) : 0;
        end else if (if_pick) begin
          m_busy = 1; m_own_d = 0; m_addr = i_if_addr; m_we = 0;
          m_width = 2'd2; m_zext = 0; m_wdata = '0;
          m_streak = 0;
        end
      end else if (m_resp) begin
        m_busy = 0; m_issued = 0; m_resp = 0; m_flushed = 0;
      end else if (!m_issued) begin
        if (i_mem_ready) m_issued = 1;
      end else if (i_mem_rvalid) begin
        m_resp = 1;
        m_data = m_we ? '0 : i_mem_rdata;
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ready(input bit data);
    bit ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge i_clk);
      if (data ? o_d_ready : o_if_ready) begin
        ok = 1;
        break;
      end
    end
    step();
    check(data ? "d_ready_seen" : "if_ready_seen", 64'(ok), 64'h1);
  endtask

  task automatic wait_rvalid(input bit data, output logic [DATA_W-1:0] rd, output int cyc);
    rd  = '0;
    cyc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (data ? o_d_rvalid : o_if_rvalid) begin
        rd  = data ? o_d_rdata : o_if_rdata;
        cyc = k;
        break;
      end
    end
    step();
    check(data ? "d_rvalid_seen" : "if_rvalid_seen", 64'(cyc >= 0), 64'h1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  bit exp_grants [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin : main
    logic [DATA_W-1:0] rd;
    int cyc, n_issue, n_stable, n_pulse;
    bit seen;
    i_if_valid = 0; i_if_addr = '0; i_if_flush = 0;
    i_d_valid = 0; i_d_addr = '0; i_d_we = 0; i_d_width = 2'd0;
    i_d_zeroextend = 0; i_d_wdata = '0;
    i_rst_n = 1'b1;
    #1 i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_mem_valid", 64'(o_mem_valid), 64'h0);
    check("reset_readies",   64'({o_if_ready, o_d_ready}), 64'h0);
    @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    step();

    // Zero-wait word load: accept c0, issue c1, response pulse c3.
    mem_data = 32'hDEAD_BEEF;
    i_d_valid = 1; i_d_addr = 32'h2000_0010; i_d_we = 0; i_d_width = 2'd2;
    @(negedge i_clk);
    check("t1_ready_c0", 64'(o_d_ready), 64'h1);
    step();
    i_d_valid = 0;
    @(negedge i_clk);
    check("t1_mem_valid_c1", 64'(o_mem_valid), 64'h1);
    check("t1_mem_addr_c1",  64'(o_mem_addr),  64'h2000_0010);
    @(negedge i_clk);
    check("t1_mem_valid_c2", 64'(o_mem_valid), 64'h0);
    check("t1_rvalid_c2",    64'(o_d_rvalid),  64'h0);
    @(negedge i_clk);
    check("t1_rvalid_c3", 64'(o_d_rvalid), 64'h1);
    check("t1_rdata_c3",  64'(o_d_rdata),  64'hDEAD_BEEF);
    @(negedge i_clk);
    check("t1_rvalid_c4", 64'(o_d_rvalid), 64'h0);
    check("t1_rdata_hold", 64'(o_d_rdata), 64'hDEAD_BEEF);
    step();

    // Starvation: store and fetch held valid together.
    grant_log.delete();
    mem_data = 32'hCAFE_F00D;
    i_d_valid = 1; i_d_we = 1; i_d_addr = 32'h2000_0100; i_d_width = 2'd2;
    i_d_wdata = 32'h1122_3344;
    i_if_valid = 1; i_if_addr = 32'h1000_0000;
    for (int k = 0; k < 80 && grant_log.size() < 10; k++) @(negedge i_clk);
    step();
    i_d_valid = 0; i_if_valid = 0;
    check("t2_grant_count", 64'(grant_log.size()), 64'd10);
    if (grant_log.size() == 10)
      for (int g = 0; g < 10; g++) check($sformatf("t2_grant_%0d", g),
                                         64'(grant_log[g]), 64'(exp_grants[g]));
    repeat (4) step();

    // Byte store with a 5-cycle ready stall; requester lines change after accept.
    mem_wait = 5; mem_data = 32'h1234_5678;
    step();
    i_d_valid = 1; i_d_we = 1; i_d_addr = 32'h2000_0200; i_d_width = 2'd0;
    i_d_wdata = 32'h0000_00AB;
    wait_ready(1);
    i_d_valid = 0; i_d_addr = 32'hFFFF_FFFF; i_d_wdata = 32'hFFFF_FFFF; i_d_width = 2'd2;
    n_issue = 0; n_stable = 0; seen = 0; rd = '1;
    for (int k = 0; k < 30; k++) begin
      @(negedge i_clk);
      if (o_mem_valid) begin
        n_issue++;
        if (o_mem_addr == 32'h2000_0200 && o_mem_wdata == 32'h0000_00AB &&
            o_mem_width == 2'd0 && o_mem_we) n_stable++;
      end
      if (o_d_rvalid) begin
        seen = 1;
        rd   = o_d_rdata;
        break;
      end
    end
    step();
    check("t3_issue_cycles",  64'(n_issue),  64'd6);
    check("t3_stable_cycles", 64'(n_stable), 64'd6);
    check("t3_rvalid_seen",   64'(seen),     64'h1);
    check("t3_store_rdata",   64'(rd),       64'h0);
    mem_wait = 0;
    i_d_we = 0; i_d_addr = '0; i_d_wdata = '0;
    step();

    // Fetch flushed during WAIT: no response pulse, next fetch returns normally.
    rsp_delay = 2; mem_data = 32'h0000_1111;
    step();
    i_if_valid = 1; i_if_addr = 32'h1000_0000;
    wait_ready(0);
    i_if_valid = 0;
    step();
    i_if_flush = 1;
    step();
    i_if_flush = 0;
    n_pulse = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clk);
      if (o_if_rvalid) n_pulse++;
    end
    step();
    check("t4_flushed_pulses", 64'(n_pulse), 64'd0);
    rsp_delay = 0; mem_data = 32'h0BAD_F00D;
    i_if_valid = 1; i_if_addr = 32'h1000_0008;
    wait_ready(0);
    i_if_valid = 0;
    wait_rvalid(0, rd, cyc);
    check("t4_next_rdata",   64'(rd),  64'h0BAD_F00D);
    check("t4_next_latency", 64'(cyc), 64'd2);

    // Flush in the accept cycle itself does not discard the fetch.
    mem_data = 32'h3333_4444;
    i_if_valid = 1; i_if_flush = 1; i_if_addr = 32'h1000_0010;
    wait_ready(0);
    i_if_valid = 0; i_if_flush = 0;
    wait_rvalid(0, rd, cyc);
    check("t4b_same_cycle_flush", 64'(rd), 64'h3333_4444);

    // Asynchronous reset in WAIT, then a late downstream response.
    rsp_delay = 4; mem_data = 32'h5555_AAAA;
    step();
    i_d_valid = 1; i_d_we = 0; i_d_addr = 32'h2000_0020; i_d_width = 2'd2;
    wait_ready(1);
    i_d_valid = 0;
    step();
    #2 i_rst_n = 1'b0;
    #1;
    check("t5_mem_valid", 64'(o_mem_valid), 64'h0);
    check("t5_mem_addr",  64'(o_mem_addr),  64'h0);
    check("t5_mem_width", 64'(o_mem_width), 64'h0);
    check("t5_if_rdata",  64'(o_if_rdata),  64'h0);
    check("t5_rvalids",   64'({o_if_rvalid, o_d_rvalid}), 64'h0);
    @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    n_pulse = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clk);
      if (o_d_rvalid || o_if_rvalid) n_pulse++;
    end
    check("t5_late_rvalid_pulses", 64'(n_pulse), 64'd0);
    rsp_delay = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between the CPU instruction-fetch port and the load/store data port.
- Fixed priority: data before instruction, with an anti-starvation counter that forces an instruction grant after a configurable number of back-to-back data grants.
- One transaction outstanding at a time. Requests are latched, issued downstream, and the response is routed back to the owner.
- Sits between the pipeline front-end/LSU and the memory controller. Replaces direct wiring when boot ROM, instruction memory and data memory are merged into one physical port.

Parameters:
- ADDR_W, 32, width of all address buses
- DATA_W, 32, width of read/write data buses
- STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits; range 1..15

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_if_valid  in  1  instruction fetch request
- i_if_addr  in  ADDR_W  fetch address
- o_if_ready  out  1  fetch request accepted (1-cycle pulse)
- o_if_rvalid  out  1  fetch data valid (1-cycle pulse)
- o_if_rdata  out  DATA_W  fetch data
- i_if_flush  in  1  discard any accepted, not-yet-returned fetch
- i_d_valid  in  1  data request
- i_d_addr  in  ADDR_W  data address
- i_d_we  in  1  1 = store, 0 = load
- i_d_width  in  2  0 = byte, 1 = half, 2 = word
- i_d_zeroextend  in  1  load zero-extend flag, passed through
- i_d_wdata  in  DATA_W  store data
- o_d_ready  out  1  data request accepted (1-cycle pulse)
- o_d_rvalid  out  1  data response (load data or store ack), 1-cycle pulse
- o_d_rdata  out  DATA_W  load data; 0 for stores
- o_mem_valid  out  1  downstream request valid
- i_mem_ready  in  1  downstream accepts request
- o_mem_addr  out  ADDR_W  downstream address
- o_mem_we  out  1  downstream write enable
- o_mem_width  out  2  downstream access width
- o_mem_zeroextend  out  1  downstream zero-extend
- o_mem_wdata  out  DATA_W  downstream write data
- i_mem_rvalid  in  1  downstream response valid (reads and write acks)
- i_mem_rdata  in  DATA_W  downstream read data

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, all outputs 0, latched request fields 0, starve counter 0, flush flag 0. Leaving reset takes effect on the first rising edge after deassertion.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If i_d_valid and (not i_if_valid or starve counter < STARVE_LIMIT), grant data.
  - Otherwise, if i_if_valid, grant instruction.
  - On grant: latch request fields and owner, pulse the owner's ready combinationally in the same cycle, move to ISSUE next edge.
  - Instruction fetches latch we=0, width=2, zeroextend=0.
- ISSUE: o_mem_valid=1 with latched fields held stable. Move to WAIT on the edge where i_mem_ready=1.
- WAIT: o_mem_valid=0. On i_mem_rvalid, register i_mem_rdata (0 if the latched we=1) and move to RESP.
- RESP:
  - Pulse the owner's rvalid for exactly 1 cycle with the registered data, then return to IDLE.
  - Total minimum latency from accept to rvalid is 3 cycles (zero-wait memory).
- Starve counter:
  - Increments on each data grant made while i_if_valid=1, saturating at 15.
  - Clears on any instruction grant, or on a data grant while i_if_valid=0.
- Flush:
  - i_if_flush=1 while the instruction owns ISSUE/WAIT/RESP sets a flush flag.
  - A flagged fetch still completes downstream, but o_if_rvalid is suppressed.
  - The flag clears when the FSM returns to IDLE.
  - i_if_flush in IDLE has no effect. The same-cycle accept is not flushed; flush must arrive from the cycle after o_if_ready onward.
- o_if_rdata and o_d_rdata hold their last value between pulses; only the rvalid pulse qualifies them.
- Requesters must hold valid and fields until ready. The arbiter never accepts while not in IDLE.
- Back-to-back: the earliest next accept is in the IDLE cycle following RESP.

Test Plan:
- Word load at 0x20000010, memory returns 0xDEADBEEF with zero wait: o_d_ready in cycle 0, o_mem_valid in cycle 1, o_d_rvalid=1 with o_d_rdata=0xDEADBEEF in cycle 3.
- Fetch and store both valid from reset (STARVE_LIMIT=4): store granted first. Holding both valid gives 4 data grants, then the 5th grant goes to the fetch; counter reads 0 after it.
- Store with width=0, wdata=0x000000AB, i_mem_ready held low for 5 cycles: o_mem_* stay stable for all 6 ISSUE cycles, and o_d_rvalid pulses with o_d_rdata=0.
- Fetch at 0x10000000 with i_if_flush pulsed during WAIT: downstream read completes, o_if_rvalid stays 0, and the next fetch at 0x10000008 returns normally.
- i_rst_n driven low mid-WAIT, asynchronous to the clock: all outputs drop to 0 immediately. A late i_mem_rvalid after reset produces no rvalid pulse.
